// File: rtl/xmm_pkg.sv
// Shared XMM execute-stage definitions: q15.48 format constants and the
// divider state encoding.
package xmm_pkg;

    localparam int unsigned XMM_WIDTH = 64;
    localparam int unsigned XMM_FRAC  = 48;
    localparam int unsigned XMM_ITER  = XMM_WIDTH + XMM_FRAC;

    localparam logic [XMM_WIDTH-1:0] XMM_MAX = {1'b0, {(XMM_WIDTH-1){1'b1}}};
    localparam logic [XMM_WIDTH-1:0] XMM_MIN = {1'b1, {(XMM_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FIXUP  = 2'd2,
        WB     = 2'd3
    } xmm_div_state_e;

endpackage

// File: rtl/xmm_div_step.sv
// One restoring-division step: shift a dividend bit into the partial
// remainder and subtract the divisor when it fits.
module xmm_div_step #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             bit_in,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;

    always_comb begin
        shifted = {rem_in, bit_in};
        q_bit   = (shifted >= {2'b00, divisor});
        rem_out = q_bit ? (WIDTH+1)'(shifted - {2'b00, divisor}) : shifted[WIDTH:0];
    end

endmodule

// File: rtl/xmm_fixed_divider.sv
// Iterative signed fixed-point divider: q = (a << FRAC_BITS) / b, one
// quotient bit per cycle on magnitudes, truncating and saturating.
module xmm_fixed_divider
    import xmm_pkg::*;
#(
    parameter int unsigned WIDTH     = XMM_WIDTH,
    parameter int unsigned FRAC_BITS = XMM_FRAC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_dst,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             flush,
    output logic             busy,
    output logic             wb_valid,
    output logic [4:0]       wb_addr,
    output logic [WIDTH-1:0] wb_data,
    output logic             div_by_zero,
    output logic             saturated
);

    localparam int unsigned ITER = WIDTH + FRAC_BITS;
    localparam int unsigned CW   = $clog2(ITER);
    localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    xmm_div_state_e   state;
    logic [CW-1:0]    counter;
    logic             sign;
    logic [4:0]       dst_r;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH:0]   rem;
    logic [ITER-1:0]  dq;
    logic [WIDTH-1:0] result;
    logic             sat_r;
    logic             dbz_r;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   rem_next;
    logic             q_bit;
    logic             accept;
    logic             overflow;

    assign in_ready = (state == IDLE) && reset;
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready && !flush;

    // Two's-complement negation of the most negative value yields 2^(W-1) as unsigned.
    assign mag_a = in_a[WIDTH-1] ? -in_a : in_a;
    assign mag_b = in_b[WIDTH-1] ? -in_b : in_b;

    // Negative results may reach exactly 2^(W-1); positive ones stop at 2^(W-1)-1.
    assign overflow = (|dq[ITER-1:WIDTH]) ||
                      (sign ? (dq[WIDTH-1] && |dq[WIDTH-2:0]) : dq[WIDTH-1]);

    xmm_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .divisor (divisor),
        .bit_in  (dq[ITER-1]),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    // The dividend is shifted out of dq's top while quotient bits enter at the bottom.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            counter     <= '0;
            sign        <= 1'b0;
            dst_r       <= '0;
            divisor     <= '0;
            rem         <= '0;
            dq          <= '0;
            result      <= '0;
            sat_r       <= 1'b0;
            dbz_r       <= 1'b0;
            wb_valid    <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            div_by_zero <= 1'b0;
            saturated   <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            if (flush && state != IDLE) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            dst_r   <= in_dst;
                            sign    <= in_a[WIDTH-1] ^ in_b[WIDTH-1];
                            divisor <= mag_b;
                            rem     <= '0;
                            dq      <= {mag_a, {FRAC_BITS{1'b0}}};
                            counter <= CW'(ITER - 1);
                            if (in_b == '0) begin
                                result <= in_a[WIDTH-1] ? NEG_MIN : POS_MAX;
                                sat_r  <= 1'b1;
                                dbz_r  <= 1'b1;
                                state  <= WB;
                            end else begin
                                sat_r  <= 1'b0;
                                dbz_r  <= 1'b0;
                                state  <= DIVIDE;
                            end
                        end
                    end
                    DIVIDE: begin
                        rem     <= rem_next;
                        dq      <= {dq[ITER-2:0], q_bit};
                        counter <= counter - 1'b1;
                        if (counter == '0)
                            state <= FIXUP;
                    end
                    FIXUP: begin
                        if (overflow)
                            result <= sign ? NEG_MIN : POS_MAX;
                        else
                            result <= sign ? -dq[WIDTH-1:0] : dq[WIDTH-1:0];
                        sat_r <= overflow;
                        state <= WB;
                    end
                    WB: begin
                        wb_valid    <= 1'b1;
                        wb_addr     <= dst_r;
                        wb_data     <= result;
                        div_by_zero <= dbz_r;
                        saturated   <= sat_r;
                        state       <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_xmm_fixed_divider.sv
// Directed bench for xmm_fixed_divider: hand-computed quotients, latency,
// saturation, divide-by-zero, flush and mid-operation reset.
module tb_xmm_fixed_divider;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_dst = '0;
    logic [63:0] in_a = '0;
    logic [63:0] in_b = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic        div_by_zero;
    logic        saturated;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xmm_fixed_divider #(.WIDTH(64), .FRAC_BITS(48)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_dst      (in_dst),
        .in_a        (in_a),
        .in_b        (in_b),
        .flush       (flush),
        .busy        (busy),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .div_by_zero (div_by_zero),
        .saturated   (saturated)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [4:0] dst,
                          input logic [63:0] exp_q, input logic exp_dbz, input logic exp_sat,
                          input int exp_lat, input string tag);
        int   n;
        logic seen;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_dst   = dst;
        check({tag, " ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 300) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (wb_valid) seen = 1'b1;
        end
        check({tag, " wb_seen"}, 64'(seen), 64'd1);
        check({tag, " latency"}, 64'(n), 64'(exp_lat));
        check({tag, " data"}, wb_data, exp_q);
        check({tag, " addr"}, 64'(wb_addr), 64'(dst));
        check({tag, " dbz"}, 64'(div_by_zero), 64'(exp_dbz));
        check({tag, " sat"}, 64'(saturated), 64'(exp_sat));
        check({tag, " ready_in_wb"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        check({tag, " pulse_drop"}, 64'(wb_valid), 64'd0);
        check({tag, " data_hold"}, wb_data, exp_q);
    endtask

    task automatic expect_no_wb(input int cycles, input string tag);
        int hits = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (wb_valid) hits++;
        end
        check({tag, " no_wb"}, 64'(hits), 64'd0);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst wb_valid", 64'(wb_valid), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst wb_data", wb_data, 64'd0);
        check("rst wb_addr", 64'(wb_addr), 64'd0);
        check("rst flags", {62'd0, div_by_zero, saturated}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst ready", 64'(in_ready), 64'd1);
        check("post_rst busy", 64'(busy), 64'd0);

        run_op(64'h0001_0000_0000_0000, 64'h0002_0000_0000_0000, 5'd3,
               64'h0000_8000_0000_0000, 1'b0, 1'b0, 114, "one_half");
        run_op(64'hFFFD_0000_0000_0000, 64'h0002_0000_0000_0000, 5'd7,
               64'hFFFE_8000_0000_0000, 1'b0, 1'b0, 114, "neg_3_2");
        run_op(64'h0001_0000_0000_0000, 64'h0003_0000_0000_0000, 5'd0,
               64'h0000_5555_5555_5555, 1'b0, 1'b0, 114, "one_third");
        run_op(64'h4000_0000_0000_0000, 64'h0000_0000_0000_0001, 5'd9,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 114, "ovf_pos");
        run_op(64'h8000_0000_0000_0000, 64'hFFFF_0000_0000_0000, 5'd10,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 114, "min_neg1");
        run_op(64'h8000_0000_0000_0000, 64'h0001_0000_0000_0000, 5'd11,
               64'h8000_0000_0000_0000, 1'b0, 1'b0, 114, "min_exact");
        run_op(64'hFFFF_0000_0000_0000, 64'h0000_0000_0000_0000, 5'd12,
               64'h8000_0000_0000_0000, 1'b1, 1'b1, 1, "dbz_neg");
        run_op(64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 5'd13,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1, "dbz_zero");

        // Flush sampled at edge T+51 while dividing
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 64'h0001_0000_0000_0000;
        in_b     = 64'h0002_0000_0000_0000;
        in_dst   = 5'd21;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (50) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush busy_before", 64'(busy), 64'd1);
        @(negedge clk);
        check("flush ready", 64'(in_ready), 64'd1);
        check("flush busy", 64'(busy), 64'd0);
        // Flush wins over a request in IDLE
        in_valid = 1'b1;
        @(negedge clk);
        check("flush blocks_accept", 64'(busy), 64'd0);
        in_valid = 1'b0;
        flush    = 1'b0;
        expect_no_wb(130, "flush");
        run_op(64'hFFFD_0000_0000_0000, 64'h0002_0000_0000_0000, 5'd22,
               64'hFFFE_8000_0000_0000, 1'b0, 1'b0, 114, "after_flush");

        // Reset asserted at T+20
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 64'h0001_0000_0000_0000;
        in_b     = 64'h0003_0000_0000_0000;
        in_dst   = 5'd30;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst wb_data", wb_data, 64'd0);
        check("midrst wb_addr", 64'(wb_addr), 64'd0);
        check("midrst flags", {62'd0, div_by_zero, saturated}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        expect_no_wb(130, "midrst");
        run_op(64'h0001_0000_0000_0000, 64'h0002_0000_0000_0000, 5'd31,
               64'h0000_8000_0000_0000, 1'b0, 1'b0, 114, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
